// File: rtl/sd_host_cmd.sv
// SD CMD-line host: divides wb_clk into the card clock, sends 48-bit command
// frames with CRC7 and collects/checks 48-bit or 136-bit responses.
module sd_host_cmd #(
  parameter int CLK_DIV = 2,
  parameter int TIMEOUT = 64
) (
  input  logic         wb_clk,
  input  logic         wb_rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [5:0]   cmd_index,
  input  logic [31:0]  cmd_arg,
  input  logic [1:0]   rsp_type,
  output logic         rsp_valid,
  output logic [5:0]   rsp_index,
  output logic [127:0] rsp_data,
  output logic         rsp_crc_err,
  output logic         rsp_timeout,
  output logic         sd_clk_o,
  output logic         sd_cmd_o,
  output logic         sd_cmd_t,
  input  logic         sd_cmd_i
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = (TW > 8) ? TW : 8;

  typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, GAP} state_t;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  function automatic logic [6:0] crc7_40(input logic [39:0] bits);
    logic [6:0] c;
    c = '0;
    for (int i = 39; i >= 0; i--) c = crc7_step(c, bits[i]);
    return c;
  endfunction

  state_t         state_q, state_d;
  logic [DW-1:0]  div_cnt_q, div_cnt_d;
  logic           sd_clk_q, sd_clk_d;
  logic           cmd_o_q, cmd_o_d;
  logic           cmd_t_q, cmd_t_d;
  logic [47:0]    tx_q, tx_d;
  logic [127:0]   rx_q, rx_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [6:0]     crc_q, crc_d;
  logic [1:0]     type_q, type_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [5:0]     rsp_index_q, rsp_index_d;
  logic [127:0]   rsp_data_q, rsp_data_d;
  logic           crc_err_q, crc_err_d;
  logic           timeout_q, timeout_d;

  logic           wrap, rise_tick, fall_tick, is_r2, crc_en;
  logic [CW-1:0]  n_bits;

  assign wrap      = (div_cnt_q == DW'(CLK_DIV - 1));
  assign rise_tick = wrap & ~sd_clk_q;
  assign fall_tick = wrap & sd_clk_q;
  assign is_r2     = (type_q == 2'b10);
  assign n_bits    = is_r2 ? CW'(136) : CW'(48);
  // cnt_q is the position of the incoming bit; R2 skips its 8-bit header in the CRC
  assign crc_en    = is_r2 ? (cnt_q >= CW'(8) && cnt_q < CW'(128)) : (cnt_q < CW'(40));

  always_comb begin
    div_cnt_d   = wrap ? '0 : div_cnt_q + DW'(1);
    sd_clk_d    = sd_clk_q ^ wrap;
    state_d     = state_q;
    cmd_o_d     = cmd_o_q;
    cmd_t_d     = cmd_t_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    cnt_d       = cnt_q;
    crc_d       = crc_q;
    type_d      = type_q;
    rsp_valid_d = 1'b0;
    rsp_index_d = rsp_index_q;
    rsp_data_d  = rsp_data_q;
    crc_err_d   = crc_err_q;
    timeout_d   = timeout_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          type_d  = rsp_type;
          tx_d    = {2'b01, cmd_index, cmd_arg, crc7_40({2'b01, cmd_index, cmd_arg}), 1'b1};
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (fall_tick) begin
          if (cnt_q == CW'(48)) begin
            cmd_t_d = 1'b1;
            cmd_o_d = 1'b1;
            cnt_d   = '0;
            if (type_q == 2'b00) begin
              rsp_valid_d = 1'b1;
              rsp_index_d = 6'h3F;
              crc_err_d   = 1'b0;
              timeout_d   = 1'b0;
              state_d     = GAP;
            end else begin
              state_d = WAIT;
            end
          end else begin
            cmd_t_d = 1'b0;
            cmd_o_d = tx_q[47];
            tx_d    = {tx_q[46:0], 1'b0};
            cnt_d   = cnt_q + CW'(1);
          end
        end
      end
      WAIT: begin
        if (rise_tick) begin
          if (!sd_cmd_i) begin
            // start bit already counted; CRC of a leading zero is still zero
            rx_d    = '0;
            crc_d   = '0;
            cnt_d   = CW'(1);
            state_d = RECV;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            rsp_valid_d = 1'b1;
            timeout_d   = 1'b1;
            crc_err_d   = 1'b0;
            cnt_d       = '0;
            state_d     = GAP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      RECV: begin
        if (cnt_q == n_bits) begin
          rsp_valid_d = 1'b1;
          timeout_d   = 1'b0;
          crc_err_d   = ~rx_q[0] | ((type_q != 2'b11) && (crc_q != rx_q[7:1]));
          if (is_r2) begin
            rsp_index_d = 6'h3F;
            rsp_data_d  = rx_q;
          end else begin
            rsp_index_d = rx_q[45:40];
            rsp_data_d  = {96'b0, rx_q[39:8]};
          end
          cnt_d   = '0;
          state_d = GAP;
        end else if (rise_tick) begin
          rx_d  = {rx_q[126:0], sd_cmd_i};
          cnt_d = cnt_q + CW'(1);
          if (crc_en) crc_d = crc7_step(crc_q, sd_cmd_i);
        end
      end
      GAP: begin
        if (rise_tick) begin
          if (cnt_q == CW'(7)) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q     <= IDLE;
      div_cnt_q   <= '0;
      sd_clk_q    <= 1'b0;
      cmd_o_q     <= 1'b1;
      cmd_t_q     <= 1'b1;
      tx_q        <= '0;
      rx_q        <= '0;
      cnt_q       <= '0;
      crc_q       <= '0;
      type_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_index_q <= '0;
      rsp_data_q  <= '0;
      crc_err_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      sd_clk_q    <= sd_clk_d;
      cmd_o_q     <= cmd_o_d;
      cmd_t_q     <= cmd_t_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      cnt_q       <= cnt_d;
      crc_q       <= crc_d;
      type_q      <= type_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_index_q <= rsp_index_d;
      rsp_data_q  <= rsp_data_d;
      crc_err_q   <= crc_err_d;
      timeout_q   <= timeout_d;
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_index   = rsp_index_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_crc_err = crc_err_q;
  assign rsp_timeout = timeout_q;
  assign sd_clk_o    = sd_clk_q;
  assign sd_cmd_o    = cmd_o_q;
  assign sd_cmd_t    = cmd_t_q;
endmodule

// File: tb/tb_sd_host_cmd.sv
// Directed bench for sd_host_cmd: captures the serial command stream and plays
// a card that answers with hand-built response frames.
module tb_sd_host_cmd;
  localparam int CLK_DIV = 2;
  localparam int TIMEOUT = 64;

  logic         wb_clk = 1'b0;
  logic         wb_rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [5:0]   cmd_index = '0;
  logic [31:0]  cmd_arg = '0;
  logic [1:0]   rsp_type = '0;
  logic         rsp_valid;
  logic [5:0]   rsp_index;
  logic [127:0] rsp_data;
  logic         rsp_crc_err;
  logic         rsp_timeout;
  logic         sd_clk_o;
  logic         sd_cmd_o;
  logic         sd_cmd_t;
  logic         sd_cmd_i = 1'b1;

  int vectors = 0;
  int miscompares = 0;

  sd_host_cmd #(.CLK_DIV(CLK_DIV), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_index(cmd_index), .cmd_arg(cmd_arg), .rsp_type(rsp_type),
    .rsp_valid(rsp_valid), .rsp_index(rsp_index), .rsp_data(rsp_data),
    .rsp_crc_err(rsp_crc_err), .rsp_timeout(rsp_timeout),
    .sd_clk_o(sd_clk_o), .sd_cmd_o(sd_cmd_o), .sd_cmd_t(sd_cmd_t), .sd_cmd_i(sd_cmd_i)
  );

  always #5 wb_clk = ~wb_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  function automatic logic [6:0] tb_crc7(input logic [119:0] d);
    logic [6:0] c;
    logic fb;
    c = '0;
    for (int i = 119; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] typ);
    @(negedge wb_clk);
    cmd_valid = 1'b1; cmd_index = idx; cmd_arg = arg; rsp_type = typ;
    @(negedge wb_clk);
    cmd_valid = 1'b0;
  endtask

  task automatic capture_tx(output logic [47:0] bits, output bit ok);
    bits = '0;
    ok = 1'b0;
    for (int k = 0; k < 2*CLK_DIV + 2; k++) begin
      if (!sd_cmd_t) begin ok = 1'b1; break; end
      @(negedge wb_clk);
    end
    if (ok) begin
      for (int b = 0; b < 48; b++) begin
        @(posedge sd_clk_o); #1;
        bits = {bits[46:0], sd_cmd_o};
      end
    end
  endtask

  task automatic card_reply(input int rlen, input logic [135:0] frame);
    repeat (2) @(negedge sd_clk_o);
    for (int i = rlen - 1; i >= 0; i--) begin
      sd_cmd_i = frame[i];
      if (i > 0) @(negedge sd_clk_o);
    end
  endtask

  // sel=0 waits for rsp_valid, sel=1 for cmd_ready; counts sd_clk rises meanwhile
  task automatic wait_event(input bit sel, input int max_cycles, output bit seen, output int rise_cnt);
    logic prev;
    prev = sd_clk_o;
    seen = 1'b0;
    rise_cnt = 0;
    for (int c = 0; c < max_cycles; c++) begin
      @(posedge wb_clk); #1;
      if (sd_clk_o && !prev) rise_cnt++;
      prev = sd_clk_o;
      if ((sel ? cmd_ready : rsp_valid) === 1'b1) begin seen = 1'b1; break; end
    end
  endtask

  task automatic do_xfer(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] typ,
                         input int rlen, input logic [135:0] rframe, input bit respond,
                         output logic [47:0] tx, output bit tx_ok, output bit seen, output int rise_cnt);
    issue(idx, arg, typ);
    capture_tx(tx, tx_ok);
    @(negedge sd_clk_o); #1;
    if (respond) card_reply(rlen, rframe);
    wait_event(1'b0, 2*CLK_DIV*(TIMEOUT + 8), seen, rise_cnt);
    $display("xfer idx=%0d type=%0d tx=%h seen=%0b idx_out=%h data=%h crc_err=%0b timeout=%0b",
             idx, typ, tx, seen, rsp_index, rsp_data, rsp_crc_err, rsp_timeout);
  endtask

  task automatic settle(output int rises);
    bit seen;
    sd_cmd_i = 1'b1;
    wait_event(1'b1, 2*CLK_DIV*20, seen, rises);
    if (!seen) rises = -1;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge wb_clk);
    vectors++;
    if ({cmd_ready, rsp_valid, rsp_index, rsp_data, rsp_crc_err, rsp_timeout, sd_clk_o, sd_cmd_o, sd_cmd_t}
        !== {1'b1, 1'b0, 6'h0, 128'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_state: got rdy=%0b v=%0b idx=%h data=%h ce=%0b to=%0b clk=%0b o=%0b t=%0b, required 1 0 00 0 0 0 0 1 1",
               cmd_ready, rsp_valid, rsp_index, rsp_data, rsp_crc_err, rsp_timeout, sd_clk_o, sd_cmd_o, sd_cmd_t);
    end
    wb_rst = 1'b0;
    $display("reset released at %0t", $time);
  endtask

  task automatic test_cmd0;
    logic [47:0] tx;
    bit ok;
    bit seen;
    int rises;
    issue(6'd0, 32'd0, 2'b00);
    capture_tx(tx, ok);
    vectors++;
    if (ok !== 1'b1 || tx !== 48'h400000000095) begin
      miscompares++;
      $display("FAIL cmd0_stream: got ok=%0b tx=%h, required ok=1 tx=400000000095", ok, tx);
    end
    @(negedge sd_clk_o); #1;
    vectors++;
    if ({sd_cmd_t, sd_cmd_o} !== 2'b11) begin
      miscompares++;
      $display("FAIL cmd0_release: got t=%0b o=%0b, required 1 1", sd_cmd_t, sd_cmd_o);
    end
    vectors++;
    if ({rsp_valid, rsp_crc_err, rsp_timeout, rsp_index} !== {1'b1, 1'b0, 1'b0, 6'h3F}) begin
      miscompares++;
      $display("FAIL cmd0_rsp: got v=%0b ce=%0b to=%0b idx=%h, required 1 0 0 3f",
               rsp_valid, rsp_crc_err, rsp_timeout, rsp_index);
    end
    @(posedge wb_clk); #1;
    vectors++;
    if (rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL cmd0_pulse_width: got rsp_valid=%0b one cycle later, required 0", rsp_valid);
    end
    wait_event(1'b1, 2*CLK_DIV*20, seen, rises);
    vectors++;
    if (seen !== 1'b1 || rises !== 8) begin
      miscompares++;
      $display("FAIL cmd0_gap: got ready=%0b after %0d rises, required ready=1 after 8", seen, rises);
    end
    $display("xfer idx=0 type=0 tx=%h gap_rises=%0d", tx, rises);
  endtask

  task automatic test_cmd8;
    logic [47:0] tx;
    bit ok;
    bit seen;
    int rises;
    do_xfer(6'd8, 32'h1AA, 2'b01, 48, {88'h0, 48'h08000001AA13}, 1'b1, tx, ok, seen, rises);
    vectors++;
    if (ok !== 1'b1 || tx !== 48'h48000001AA87) begin
      miscompares++;
      $display("FAIL cmd8_stream: got ok=%0b tx=%h, required ok=1 tx=48000001aa87", ok, tx);
    end
    vectors++;
    if ({seen, rsp_index, rsp_data, rsp_crc_err, rsp_timeout} !== {1'b1, 6'd8, 128'h1AA, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL cmd8_rsp: got v=%0b idx=%h data=%h ce=%0b to=%0b, required 1 08 1aa 0 0",
               seen, rsp_index, rsp_data, rsp_crc_err, rsp_timeout);
    end
    @(posedge wb_clk); #1;
    vectors++;
    if (rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL cmd8_pulse_width: got rsp_valid=%0b, required 0", rsp_valid);
    end
    settle(rises);
    vectors++;
    if (rises < 7 || rises > 8) begin
      miscompares++;
      $display("FAIL cmd8_gap: got %0d rises before ready, required 7..8", rises);
    end
  endtask

  task automatic test_crc_err;
    logic [47:0] tx;
    bit ok;
    bit seen;
    int rises;
    logic [47:0] frames [4];
    logic [1:0]  types  [4];
    logic        exp_err[4];
    logic [31:0] exp_dat[4];
    frames[0] = 48'h08000011AA13; types[0] = 2'b01; exp_err[0] = 1'b1; exp_dat[0] = 32'h11AA;
    frames[1] = 48'h08000011AA13; types[1] = 2'b11; exp_err[1] = 1'b0; exp_dat[1] = 32'h11AA;
    frames[2] = 48'h08000001AA12; types[2] = 2'b01; exp_err[2] = 1'b1; exp_dat[2] = 32'h1AA;
    frames[3] = 48'h08000001AA12; types[3] = 2'b11; exp_err[3] = 1'b1; exp_dat[3] = 32'h1AA;
    for (int n = 0; n < 4; n++) begin
      do_xfer(6'd8, 32'h1AA, types[n], 48, {88'h0, frames[n]}, 1'b1, tx, ok, seen, rises);
      vectors++;
      if ({seen, rsp_crc_err, rsp_timeout, rsp_index, rsp_data} !== {1'b1, exp_err[n], 1'b0, 6'd8, 96'h0, exp_dat[n]}) begin
        miscompares++;
        $display("FAIL crc_case%0d: got v=%0b ce=%0b to=%0b idx=%h data=%h, required 1 %0b 0 08 %h",
                 n, seen, rsp_crc_err, rsp_timeout, rsp_index, rsp_data, exp_err[n], exp_dat[n]);
      end
      settle(rises);
    end
  endtask

  task automatic test_timeout;
    logic [47:0] tx;
    bit ok;
    bit seen;
    int rises;
    do_xfer(6'd8, 32'h1AA, 2'b01, 48, 136'h0, 1'b0, tx, ok, seen, rises);
    vectors++;
    if ({seen, rsp_timeout, rsp_crc_err} !== 3'b110 || rises !== TIMEOUT) begin
      miscompares++;
      $display("FAIL timeout_flags: got v=%0b to=%0b ce=%0b rises=%0d, required 1 1 0 rises=%0d",
               seen, rsp_timeout, rsp_crc_err, rises, TIMEOUT);
    end
    vectors++;
    if (rsp_data !== 128'h1AA) begin
      miscompares++;
      $display("FAIL timeout_data_hold: got %h, required 1aa", rsp_data);
    end
    settle(rises);
  endtask

  task automatic test_r2;
    logic [47:0]  tx;
    bit ok;
    bit seen;
    int rises;
    logic [119:0] cid;
    logic [135:0] frame;
    cid   = 120'h0353445344333247801234567800A5;
    frame = {2'b00, 6'h3F, cid, tb_crc7(cid), 1'b1};
    do_xfer(6'd2, 32'h0, 2'b10, 136, frame, 1'b1, tx, ok, seen, rises);
    vectors++;
    if ({seen, rsp_index, rsp_data, rsp_crc_err, rsp_timeout} !== {1'b1, 6'h3F, frame[127:0], 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL r2_good: got v=%0b idx=%h data=%h ce=%0b to=%0b, required 1 3f %h 0 0",
               seen, rsp_index, rsp_data, rsp_crc_err, rsp_timeout, frame[127:0]);
    end
    settle(rises);
    frame[60] = ~frame[60];
    do_xfer(6'd2, 32'h0, 2'b10, 136, frame, 1'b1, tx, ok, seen, rises);
    vectors++;
    if ({seen, rsp_crc_err, rsp_data} !== {1'b1, 1'b1, frame[127:0]}) begin
      miscompares++;
      $display("FAIL r2_bad_crc: got v=%0b ce=%0b data=%h, required 1 1 %h",
               seen, rsp_crc_err, rsp_data, frame[127:0]);
    end
    settle(rises);
  endtask

  task automatic test_reset_mid;
    logic [47:0] bits;
    int pulses;
    issue(6'h11, 32'hDEADBEEF, 2'b01);
    for (int k = 0; k < 2*CLK_DIV + 2 && sd_cmd_t; k++) @(negedge wb_clk);
    repeat (20) @(posedge sd_clk_o);
    @(negedge wb_clk);
    wb_rst = 1'b1;
    @(negedge wb_clk);
    vectors++;
    if ({cmd_ready, rsp_valid, rsp_index, rsp_data, rsp_crc_err, rsp_timeout, sd_clk_o, sd_cmd_o, sd_cmd_t}
        !== {1'b1, 1'b0, 6'h0, 128'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_mid_frame: got rdy=%0b v=%0b idx=%h data=%h ce=%0b to=%0b clk=%0b o=%0b t=%0b, required 1 0 00 0 0 0 0 1 1",
               cmd_ready, rsp_valid, rsp_index, rsp_data, rsp_crc_err, rsp_timeout, sd_clk_o, sd_cmd_o, sd_cmd_t);
    end
    wb_rst = 1'b0;
    pulses = 0;
    bits = '0;
    for (int c = 0; c < 400; c++) begin
      @(posedge wb_clk); #1;
      if (rsp_valid !== 1'b0 || sd_cmd_t !== 1'b1) pulses++;
      bits = {bits[46:0], sd_cmd_o};
    end
    vectors++;
    if (pulses !== 0) begin
      miscompares++;
      $display("FAIL reset_abandon: got %0d cycles with rsp_valid or CMD driven, required 0", pulses);
    end
    $display("reset mid-frame: idle line history=%h", bits);
  endtask

  task automatic test_back_to_back;
    int accepts;
    int pulses;
    int rises_since;
    int bad_gap;
    int double_ready;
    logic prev_clk;
    logic prev_rdy;
    bit seen;
    int rises;
    accepts = 0; pulses = 0; rises_since = 100; bad_gap = 0; double_ready = 0;
    prev_clk = sd_clk_o; prev_rdy = 1'b0;
    @(negedge wb_clk);
    cmd_valid = 1'b1; cmd_index = 6'd0; cmd_arg = 32'h0; rsp_type = 2'b00;
    for (int c = 0; c < 2000 && accepts < 3; c++) begin
      if (c > 0) @(negedge wb_clk);
      if (cmd_ready === 1'b1) begin
        if (prev_rdy) double_ready++;
        accepts++;
        if (rises_since != 100 && rises_since != 8) bad_gap++;
        $display("accept #%0d at %0t, rises since last rsp_valid=%0d", accepts, $time, rises_since);
      end
      prev_rdy = cmd_ready;
      @(posedge wb_clk); #1;
      if (sd_clk_o && !prev_clk) rises_since++;
      prev_clk = sd_clk_o;
      if (rsp_valid === 1'b1) begin pulses++; rises_since = 0; end
    end
    cmd_valid = 1'b0;
    vectors++;
    if (accepts !== 3 || pulses !== 2 || double_ready !== 0) begin
      miscompares++;
      $display("FAIL b2b_accepts: got accepts=%0d pulses=%0d repeated_ready=%0d, required 3 2 0",
               accepts, pulses, double_ready);
    end
    vectors++;
    if (bad_gap !== 0) begin
      miscompares++;
      $display("FAIL b2b_gap: got %0d acceptances not 8 rises after rsp_valid, required 0", bad_gap);
    end
    wait_event(1'b0, 2*CLK_DIV*60, seen, rises);
    settle(rises);
  endtask

  initial begin
    test_reset;
    test_cmd0;
    test_cmd8;
    test_crc_err;
    test_timeout;
    test_r2;
    test_reset_mid;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
